// File: rtl/systolic_drain_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : systolic_drain_pkg
//  Description : Shared widths and the requantisation helper for the
//                systolic-array output drain stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package systolic_drain_pkg;

    // Default geometry of the array interface
    localparam int c_n_banks    = 2;
    localparam int c_n_cols     = 4;
    localparam int c_o_width    = 33;
    localparam int c_q_width    = 16;
    localparam int c_fifo_depth = 8;

    // Largest useful shift: beyond this a 33-bit value is only sign bits
    localparam logic [5:0] c_shift_max = 6'd32;

    // Saturation bounds expressed at accumulator width
    localparam logic signed [c_o_width-1:0] c_q_max =
        c_o_width'((64'sd1 <<< (c_q_width - 1)) - 64'sd1);
    localparam logic signed [c_o_width-1:0] c_q_min =
        c_o_width'(-(64'sd1 <<< (c_q_width - 1)));

    // Arithmetic right shift, optional ReLU, then clamp into the
    // signed output range.
    function automatic logic signed [c_q_width-1:0] quantise(
        input logic signed [c_o_width-1:0] v,
        input logic        [5:0]           sh,
        input logic                        relu
    );
        logic signed [c_o_width-1:0] s;
        s = v >>> sh;
        if (relu && (s < 0)) begin
            s = '0;
        end
        if (s > c_q_max) begin
            s = c_q_max;
        end else if (s < c_q_min) begin
            s = c_q_min;
        end
        return s[c_q_width-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/drain_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : drain_fifo
//  Description : Synchronous FIFO with occupancy count. The head entry is
//                read straight out of the storage registers so it is stable
//                while the consumer stalls.
//  Revision    : 1.0 - initial release
// ============================================================================
module drain_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_data,
    output logic                       o_valid,
    output logic                       o_full,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int c_aw = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_aw:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == (c_aw + 1)'(DEPTH));
    assign o_valid = (r_count != '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];

    // A push into a full FIFO or a pop from an empty one is ignored
    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && o_valid;

    // Storage, pointers and occupancy; reset also clears storage so the
    // head reads zero after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/systolic_drain.sv
`default_nettype none
// ============================================================================
//  Module      : systolic_drain
//  Description : Drain stage behind the systolic array. Captures each
//                column's results into a holding register, round-robin
//                arbitrates the held columns into an output FIFO, and
//                requantises the 33-bit accumulators to 16-bit activations
//                on the way in.
//  Revision    : 1.0 - initial release
// ============================================================================
module systolic_drain
    import systolic_drain_pkg::*;
#(
    parameter int nBanks     = c_n_banks,
    parameter int nCols      = c_n_cols,
    parameter int oWidth     = c_o_width,
    parameter int qWidth     = c_q_width,
    parameter int FIFO_DEPTH = c_fifo_depth
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               cfg_load,
    input  logic [5:0]                         cfg_shift,
    input  logic                               cfg_relu,
    input  logic [nBanks*nCols*oWidth-1:0]     din,
    input  logic [nCols-1:0]                   din_en,
    output logic [nBanks*qWidth-1:0]           out_data,
    output logic [$clog2(nCols)-1:0]           out_col,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic                               overrun,
    output logic [$clog2(FIFO_DEPTH):0]        fifo_count
);

    localparam int c_col_w   = $clog2(nCols);
    localparam int c_word_w  = nBanks * qWidth;
    localparam int c_entry_w = c_col_w + c_word_w;
    localparam int c_hold_w  = nBanks * oWidth;

    // Configuration
    logic [5:0]              r_shift_q;
    logic                    r_relu_q;

    // Per-column holding registers
    logic [c_hold_w-1:0]     w_din_col [nCols];
    logic [c_hold_w-1:0]     r_hold    [nCols];
    logic [nCols-1:0]        r_hold_valid;

    // Arbiter
    logic [c_col_w-1:0]      r_rr_ptr;
    logic                    w_grant;
    logic [c_col_w-1:0]      w_grant_col;
    logic [nCols-1:0]        w_grant_vec;
    logic                    r_overrun;

    // Quantised word and FIFO interface
    logic [c_hold_w-1:0]     w_sel;
    logic [c_word_w-1:0]     w_word;
    logic [c_entry_w-1:0]    w_fifo_out;
    logic                    w_fifo_full;
    logic                    w_pop;

    // Regroup the flat array bus so each column's banks are contiguous
    for (genvar c = 0; c < nCols; c++) begin : g_col
        for (genvar b = 0; b < nBanks; b++) begin : g_bank
            assign w_din_col[c][b*oWidth +: oWidth] = din[((b*nCols)+c)*oWidth +: oWidth];
        end
        assign w_grant_vec[c] = w_grant && (w_grant_col == c_col_w'(c));
    end

    // Latch quantiser settings; shifts past 32 behave as 32
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift_q <= '0;
            r_relu_q  <= 1'b0;
        end else if (cfg_load) begin
            r_shift_q <= (cfg_shift > c_shift_max) ? c_shift_max : cfg_shift;
            r_relu_q  <= cfg_relu;
        end
    end

    // Round-robin search starting at the pointer; nothing is granted while
    // the FIFO is full, even if a pop is happening this cycle.
    always_comb begin
        int idx;
        idx         = 0;
        w_grant     = 1'b0;
        w_grant_col = '0;
        for (int i = 0; i < nCols; i++) begin
            idx = (int'(r_rr_ptr) + i) % nCols;
            if (!w_grant && !w_fifo_full && r_hold_valid[idx]) begin
                w_grant     = 1'b1;
                w_grant_col = c_col_w'(idx);
            end
        end
    end

    // Capture column results; a slot being granted this cycle may refill,
    // otherwise a new pulse into an occupied slot is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold_valid <= '0;
            for (int c = 0; c < nCols; c++) begin
                r_hold[c] <= '0;
            end
        end else begin
            for (int c = 0; c < nCols; c++) begin
                if (din_en[c] && (!r_hold_valid[c] || w_grant_vec[c])) begin
                    r_hold[c]       <= w_din_col[c];
                    r_hold_valid[c] <= 1'b1;
                end else if (w_grant_vec[c]) begin
                    r_hold_valid[c] <= 1'b0;
                end
            end
        end
    end

    // Advance the round-robin pointer past the granted column and keep the
    // sticky drop flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr  <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_grant) begin
                r_rr_ptr <= (w_grant_col == c_col_w'(nCols - 1)) ? '0 : w_grant_col + 1'b1;
            end
            if (|(din_en & r_hold_valid & ~w_grant_vec)) begin
                r_overrun <= 1'b1;
            end
        end
    end

    // Requantise every bank of the granted column independently
    assign w_sel = r_hold[w_grant_col];
    for (genvar b = 0; b < nBanks; b++) begin : g_quant
        assign w_word[b*qWidth +: qWidth] = quantise(w_sel[b*oWidth +: oWidth], r_shift_q, r_relu_q);
    end

    assign w_pop = out_valid && out_ready;

    drain_fifo #(
        .WIDTH (c_entry_w),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_grant),
        .i_data  ({w_grant_col, w_word}),
        .i_pop   (w_pop),
        .o_data  (w_fifo_out),
        .o_valid (out_valid),
        .o_full  (w_fifo_full),
        .o_count (fifo_count)
    );

    assign out_col  = w_fifo_out[c_entry_w-1 -: c_col_w];
    assign out_data = w_fifo_out[c_word_w-1:0];
    assign overrun  = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_systolic_drain.sv
`default_nettype none
// ============================================================================
//  Module      : tb_systolic_drain
//  Description : Scoreboard bench for systolic_drain. Stimulus pushes the
//                hand-computed expected words; a monitor pops and compares
//                each word the DUT hands over.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_systolic_drain;

    localparam int NB = 2;
    localparam int NC = 4;
    localparam int OW = 33;
    localparam int QW = 16;
    localparam int FD = 8;

    typedef struct packed {
        logic [1:0]  col;
        logic [31:0] data;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 cfg_load;
    logic [5:0]           cfg_shift;
    logic                 cfg_relu;
    logic [NB*NC*OW-1:0]  din;
    logic [NC-1:0]        din_en;
    logic [NB*QW-1:0]     out_data;
    logic [1:0]           out_col;
    logic                 out_valid;
    logic                 out_ready;
    logic                 overrun;
    logic [3:0]           fifo_count;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    systolic_drain #(
        .nBanks     (NB),
        .nCols      (NC),
        .oWidth     (OW),
        .qWidth     (QW),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_load   (cfg_load),
        .cfg_shift  (cfg_shift),
        .cfg_relu   (cfg_relu),
        .din        (din),
        .din_en     (din_en),
        .out_data   (out_data),
        .out_col    (out_col),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .overrun    (overrun),
        .fifo_count (fifo_count)
    );

    // Monitor: every accepted word must match the oldest expectation
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_output: got col=%0d data=%h, expected no output", out_col, out_data);
            end else begin
                e = exp_q.pop_front();
                if (out_col !== e.col || out_data !== e.data) begin
                    n_fail++;
                    $display("FAIL out_word: got col=%0d data=%h, expected col=%0d data=%h",
                             out_col, out_data, e.col, e.data);
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] expv);
        n_tests++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, expv);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_val(input int c, input int b, input logic [OW-1:0] v);
        din[((b*NC)+c)*OW +: OW] = v;
    endtask

    task automatic expect_word(input logic [1:0] col, input logic [15:0] b1, input logic [15:0] b0);
        exp_q.push_back('{col: col, data: {b1, b0}});
    endtask

    task automatic pulse(input logic [NC-1:0] en);
        din_en = en;
        tick(1);
        din_en = '0;
    endtask

    task automatic load_cfg(input logic [5:0] sh, input logic relu);
        cfg_shift = sh;
        cfg_relu  = relu;
        cfg_load  = 1'b1;
        tick(1);
        cfg_load  = 1'b0;
        tick(1);
    endtask

    task automatic wait_drain(input string name);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 200) begin
            tick(1);
            k++;
        end
        tick(2);
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        exp_q.delete();
        rst = 1'b0;
        tick(1);
    endtask

    initial begin
        rst       = 1'b1;
        cfg_load  = 1'b0;
        cfg_shift = '0;
        cfg_relu  = 1'b0;
        din       = '0;
        din_en    = '0;
        out_ready = 1'b1;
        tick(2);

        // Reset state
        check("rst_out_valid",  64'(out_valid),  64'd0);
        check("rst_out_data",   64'(out_data),   64'd0);
        check("rst_out_col",    64'(out_col),    64'd0);
        check("rst_overrun",    64'(overrun),    64'd0);
        check("rst_fifo_count", 64'(fifo_count), 64'd0);
        rst = 1'b0;
        tick(1);

        // Basic pass-through with latency check
        load_cfg(6'd0, 1'b0);
        set_val(0, 0, 100);
        set_val(0, 1, -5);
        expect_word(2'd0, 16'hFFFB, 16'h0064);
        din_en = 4'b0001;
        tick(1);
        din_en = '0;
        check("latency_t1_valid", 64'(out_valid), 64'd0);
        tick(1);
        check("latency_t2_valid", 64'(out_valid), 64'd1);
        wait_drain("basic_drain");

        // Quantiser: shift, ReLU, saturation
        load_cfg(6'd8, 1'b1);
        set_val(0, 0, 33'h0_0012_3400);
        set_val(0, 1, -4096);
        expect_word(2'd0, 16'h0000, 16'h1234);
        pulse(4'b0001);
        wait_drain("quant_relu_drain");
        set_val(0, 0, 2**30);
        expect_word(2'd0, 16'h0000, 16'h7FFF);
        pulse(4'b0001);
        wait_drain("quant_satpos_drain");
        load_cfg(6'd8, 1'b0);
        set_val(0, 0, 0);
        set_val(0, 1, -(2**30));
        expect_word(2'd0, 16'h8000, 16'h0000);
        pulse(4'b0001);
        wait_drain("quant_satneg_drain");
        load_cfg(6'd0, 1'b0);
        set_val(0, 0, 32768);
        set_val(0, 1, -32769);
        expect_word(2'd0, 16'h8000, 16'h7FFF);
        pulse(4'b0001);
        wait_drain("quant_edge_drain");
        load_cfg(6'd40, 1'b0);
        set_val(0, 0, 33'h0_FFFF_FFFF);
        set_val(0, 1, 33'h1_0000_0000);
        expect_word(2'd0, 16'hFFFF, 16'h0000);
        pulse(4'b0001);
        wait_drain("quant_bigshift_drain");

        // All columns at once from pointer 0, then a wrapped pair
        do_reset();
        for (int c = 0; c < NC; c++) begin
            set_val(c, 0, 10 * (c + 1));
            set_val(c, 1, -(c + 1));
        end
        expect_word(2'd0, 16'hFFFF, 16'h000A);
        expect_word(2'd1, 16'hFFFE, 16'h0014);
        expect_word(2'd2, 16'hFFFD, 16'h001E);
        expect_word(2'd3, 16'hFFFC, 16'h0028);
        pulse(4'b1111);
        wait_drain("rr_all_drain");
        set_val(0, 0, 7);
        set_val(0, 1, 0);
        set_val(2, 0, 9);
        set_val(2, 1, 0);
        expect_word(2'd0, 16'h0000, 16'h0007);
        expect_word(2'd2, 16'h0000, 16'h0009);
        pulse(4'b0101);
        wait_drain("rr_pair_drain");

        // Backpressure: eight in the FIFO, one held, the tenth dropped
        out_ready = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            if (k == 10) begin
                check("bp_fifo_full_count", 64'(fifo_count), 64'd8);
                check("bp_overrun_before",  64'(overrun),    64'd0);
            end
            set_val(0, 0, k * 10);
            set_val(0, 1, -k);
            if (k <= 9) expect_word(2'd0, 16'(-k), 16'(k * 10));
            pulse(4'b0001);
            tick(1);
        end
        check("bp_overrun_after", 64'(overrun), 64'd1);
        out_ready = 1'b1;
        wait_drain("bp_drain");
        check("bp_fifo_empty", 64'(fifo_count), 64'd0);

        // Refill of a slot in the same cycle it is granted
        do_reset();
        set_val(0, 0, 1);
        set_val(0, 1, 0);
        expect_word(2'd0, 16'h0000, 16'h0001);
        din_en = 4'b0001;
        tick(1);
        set_val(0, 0, 2);
        expect_word(2'd0, 16'h0000, 16'h0002);
        tick(1);
        din_en = '0;
        wait_drain("refill_drain");
        check("refill_no_overrun", 64'(overrun), 64'd0);

        // Reset in the middle of a backed-up stream
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            set_val(0, 0, 100 + k);
            pulse(4'b0001);
            tick(1);
        end
        check("mid_fifo_count", 64'(fifo_count), 64'd5);
        check("mid_out_valid",  64'(out_valid),  64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid",  64'(out_valid),  64'd0);
        check("mid_rst_fifo_count", 64'(fifo_count), 64'd0);
        check("mid_rst_overrun",    64'(overrun),    64'd0);
        exp_q.delete();
        tick(2);
        rst = 1'b0;
        out_ready = 1'b1;
        tick(10);
        set_val(1, 0, 5);
        set_val(1, 1, -1);
        expect_word(2'd1, 16'hFFFF, 16'h0005);
        pulse(4'b0010);
        wait_drain("post_rst_drain");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
